// File: rtl/safe_pkg.sv
// Shared types and helpers for the parametrised combination lock.
package safe_pkg;

    // Top-level lock state.
    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } safe_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter with a zero flag. It saturates at zero.
// One instance is shared by the idle timeout and the lockout timer.
module safe_timer
    import safe_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/param_safe.sv
// Parametrised combination lock: digit entry, open/relock, reprogramming,
// lockout after repeated wrong entries and idle expiry of partial entries.
module param_safe
    import safe_pkg::*;
#(
    parameter int unsigned                    DATA_W         = 8,
    parameter int unsigned                    CODE_LEN       = 4,
    parameter logic [CODE_LEN*DATA_W-1:0]     DEFAULT_CODE   = 32'hbaadc0de,
    parameter int unsigned                    MAX_FAILS      = 3,
    parameter int unsigned                    LOCKOUT_CYCLES = 16,
    parameter int unsigned                    TIMEOUT_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            din,
    input  logic                         din_valid,
    input  logic                         lock,
    input  logic                         prog_valid,
    input  logic [CODE_LEN*DATA_W-1:0]   prog_code,
    output logic                         unlocked,
    output logic                         locked_out,
    output logic                         fail
);

    localparam int unsigned CODE_W  = CODE_LEN * DATA_W;
    localparam int unsigned IDX_W   = cnt_w(CODE_LEN - 1);
    localparam int unsigned FAIL_W  = cnt_w(MAX_FAILS);
    // The timer is loaded with N-1 so that the zero flag marks the last
    // cycle of a window; this makes a window last exactly N cycles.
    localparam int unsigned TMR_MAX = ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ?
                                       LOCKOUT_CYCLES : TIMEOUT_CYCLES) - 1;
    localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

    safe_state_t        state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mism_q, mism_d;
    logic [FAIL_W-1:0]  fails_q, fails_d;
    logic               unlocked_q, locked_out_q, fail_q;
    logic               fail_d;

    logic [DATA_W-1:0]  code_digit [CODE_LEN];
    logic [FAIL_W-1:0]  fails_inc;
    logic               digit_bad;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_dec;
    logic               tmr_zero;

    // Split the stored code into digits, first digit in the top slice.
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_digit
            assign code_digit[gi] = code_q[CODE_W-1-gi*DATA_W -: DATA_W];
        end
    endgenerate

    assign fails_inc = fails_q + 1'b1;

    safe_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state logic for the lock FSM, entry tracking and shared timer.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        idx_d     = idx_q;
        mism_d    = mism_q;
        fails_d   = fails_q;
        fail_d    = 1'b0;
        digit_bad = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        case (state_q)
            LOCKED: begin
                if (din_valid) begin
                    digit_bad = (din != code_digit[idx_q]);
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(TIMEOUT_CYCLES - 1);
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (!mism_q && !digit_bad) begin
                            state_d = OPEN;
                            fails_d = '0;
                        end else begin
                            fail_d  = 1'b1;
                            fails_d = fails_inc;
                            if (fails_inc == FAIL_W'(MAX_FAILS)) begin
                                state_d = LOCKOUT;
                                tmr_val = TMR_W'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        mism_d = mism_q | digit_bad;
                    end
                end else if (idx_q != '0) begin
                    // Idle with a partial entry: discard it when the window ends.
                    if (tmr_zero) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (prog_valid) begin
                    code_d = prog_code;
                end
                if (lock) begin
                    state_d = LOCKED;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = LOCKED;
                    fails_d = '0;
                    idx_d   = '0;
                    mism_d  = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    // State registers; outputs are registered from the next state so they
    // track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOCKED;
            code_q       <= DEFAULT_CODE;
            idx_q        <= '0;
            mism_q       <= 1'b0;
            fails_q      <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            idx_q        <= idx_d;
            mism_q       <= mism_d;
            fails_q      <= fails_d;
            unlocked_q   <= (state_d == OPEN);
            locked_out_q <= (state_d == LOCKOUT);
            fail_q       <= fail_d;
        end
    end

    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign fail       = fail_q;

endmodule
